pwm_multi_ch: RTL and testbench

Multi-channel successor to the single-channel PWM generator. CH independent PWM outputs share one prescaler and one R-bit period counter. Each channel has double-buffered duty (pending/active), so duty changes apply only at period boundaries and never produce glitches. It sits between the control registers and the pad/driver logic and emits a period_start strobe for downstream sampling and ADC triggering.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_prescaler.sv | 38 +++
 rtl/pwm_multi_ch.sv | 152 +++++++++++++++
 tb/tb_pwm_multi_ch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_pkg : shared duty-width/slice helpers and counter direction  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pwm_pkg;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } cnt_dir_e;

   function automatic int unsigned duty_width(input int unsigned r);
      return r + 1;
   endfunction

   function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned r);
      return ch * (r + 1);
   endfunction

   // Duty values above a full period saturate to constant-high.
   function automatic int unsigned clamp_duty(input int unsigned d, input int unsigned r);
      int unsigned full;
      full = 32'd1 << r;
      return (d > full) ? full : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_prescaler : clock divider, one-clock tick every final_value+1|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pwm_prescaler #(
   parameter int TIMER_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [TIMER_BITS-1:0] final_value,
   output logic                  tick
);

   logic [TIMER_BITS-1:0] presc_q, presc_d;

   // >= lets a lowered final_value terminate the current count at once.
   always_comb begin
      tick    = 1'b0;
      presc_d = presc_q;
      if (!enable) begin
         presc_d = '0;
      end else if (presc_q >= final_value) begin
         tick    = 1'b1;
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_multi_ch : CH-channel PWM, shared counter, double-buffered   |
// | duty. Option macro: PWM_CENTER_ALIGNED_EN (up/down counting).    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter int R          = 8,
   parameter int TIMER_BITS = 8,
   parameter int CH         = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [TIMER_BITS-1:0] final_value,
   input  logic [CH*(R+1)-1:0]   duty,
   input  logic [CH-1:0]         duty_load,
   output logic [CH-1:0]         pwm_out,
   output logic                  period_start
);

   localparam int          DUTY_W  = duty_width(R);
   localparam logic [R-1:0] CNT_MAX = '1;

   logic          tick;
   logic          boundary;
   logic          apply;
   logic [R-1:0]  cnt_q, cnt_d;
   logic          en_q, en_d;
   logic          period_start_q, period_start_d;
   logic [CH-1:0] pwm_q, pwm_d;

   pwm_prescaler #(
      .TIMER_BITS (TIMER_BITS)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .final_value (final_value),
      .tick        (tick)
   );

`ifdef PWM_CENTER_ALIGNED_EN
   localparam logic [R-1:0] CNT_ONE = R'(1);

   cnt_dir_e dir_q, dir_d;

   // Up 0..MAX, down MAX-1..1; the period closes on the tick leaving 1.
   always_comb begin
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      boundary = 1'b0;
      if (!enable) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (tick) begin
         if (dir_q == DIR_UP) begin
            if (cnt_q == CNT_MAX) begin
               if (R == 1) begin
                  cnt_d    = '0;
                  boundary = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  dir_d = DIR_DOWN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) begin
               boundary = 1'b1;
               dir_d    = DIR_UP;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) dir_q <= DIR_UP;
      else       dir_q <= dir_d;
   end
`else
   always_comb begin
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (!enable) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d    = cnt_q + 1'b1;
         boundary = (cnt_q == CNT_MAX);
      end
   end
`endif

   // Disabled or first enabled clock also transfers duty, so a restart
   // always runs with the most recent pending value from count 0.
   assign apply = boundary | ~enable | ~en_q;

   always_comb begin
      en_d           = enable;
      period_start_d = boundary;
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [DUTY_W-1:0] bus_val;
      logic [DUTY_W-1:0] pending_q, pending_d;
      logic [DUTY_W-1:0] active_q, active_d;

      assign bus_val = DUTY_W'(clamp_duty(32'(duty[slice_lo(i, R) +: DUTY_W]), R));

      always_comb begin
         pending_d = pending_q;
         active_d  = active_q;
         if (duty_load[i]) pending_d = bus_val;
         if (apply)        active_d  = duty_load[i] ? bus_val : pending_q;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            pending_q <= '0;
            active_q  <= '0;
         end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
         end
      end

      assign pwm_d[i] = enable & ({1'b0, cnt_q} < active_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q          <= '0;
         en_q           <= 1'b0;
         pwm_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         en_q           <= en_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pwm_multi_ch : period-level reference model plus directed     |
// | window measurements for pwm_multi_ch.  Revision: 1.0             |
// +------------------------------------------------------------------+
module tb_pwm_multi_ch;

   localparam int R          = 8;
   localparam int TIMER_BITS = 8;
   localparam int CH         = 4;
   localparam int DW         = R + 1;
   localparam int FULL       = 1 << R;
   localparam int MAXC       = FULL - 1;
`ifdef PWM_CENTER_ALIGNED_EN
   localparam bit CENTER = 1'b1;
`else
   localparam bit CENTER = 1'b0;
`endif
   localparam int PER_T = CENTER ? 2 * MAXC : FULL;
   localparam int LIMIT = 5000;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  enable;
   logic [TIMER_BITS-1:0] final_value;
   logic [CH*DW-1:0]      duty_bus;
   logic [CH-1:0]         duty_load;
   logic [CH-1:0]         pwm_out;
   logic                  period_start;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pwm_multi_ch #(.R(R), .TIMER_BITS(TIMER_BITS), .CH(CH)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .final_value  (final_value),
      .duty         (duty_bus),
      .duty_load    (duty_load),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   // ---------------- reference model: ticks since start, modular phase ----
   int            m_phase, m_ticks;
   int            m_pend [CH];
   int            m_act  [CH];
   bit            m_en_prev;
   logic [CH-1:0] exp_pwm;
   logic          exp_ps;

   function automatic int clampv(input int d);
      return (d > FULL) ? FULL : d;
   endfunction

   always @(posedge clk) begin : model
      int p, c, v, na;
      bit tk, bnd, app;
      if (reset) begin
         m_phase = 0; m_ticks = 0; m_en_prev = 0;
         for (int k = 0; k < CH; k++) begin m_pend[k] = 0; m_act[k] = 0; end
         exp_pwm = '0; exp_ps = 1'b0;
      end else begin
         p   = m_ticks % PER_T;
         c   = (p <= MAXC) ? p : PER_T - p;
         tk  = enable && (m_phase >= int'(final_value));
         bnd = tk && (p == PER_T - 1);
         app = bnd || !enable || !m_en_prev;
         for (int k = 0; k < CH; k++) begin
            exp_pwm[k] = enable && (c < m_act[k]);
            v  = clampv(int'(duty_bus[k*DW +: DW]));
            na = m_act[k];
            if (app) na = duty_load[k] ? v : m_pend[k];
            if (duty_load[k]) m_pend[k] = v;
            m_act[k] = na;
         end
         exp_ps = bnd;
         if (!enable)  begin m_phase = 0; m_ticks = 0; end
         else if (tk)  begin m_phase = 0; m_ticks++; end
         else          m_phase++;
         m_en_prev = enable;
      end
   end

   // ---------------- helpers --------------------------------------------
   task automatic step();
      @(negedge clk);
      total++;
      if (pwm_out !== exp_pwm) begin
         bad++;
         $display("FAIL cycle_pwm t=%0t got=%b exp=%b", $time, pwm_out, exp_pwm);
      end
      total++;
      if (period_start !== exp_ps) begin
         bad++;
         $display("FAIL cycle_ps t=%0t got=%b exp=%b", $time, period_start, exp_ps);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic int per_clk(input int fv);
      return PER_T * (fv + 1);
   endfunction

   function automatic int exp_hi(input int d, input int fv);
      if (d <= 0)    return 0;
      if (d >= FULL) return per_clk(fv);
      return (CENTER ? 2 * d - 1 : d) * (fv + 1);
   endfunction

   task automatic set_slot(input int ch, input int val);
      duty_bus[ch*DW +: DW] = DW'(val);
   endtask

   int win_len;
   int win_hi [CH];

   task automatic wait_pulse();
      int n;
      n = 0;
      while (period_start !== 1'b1 && n < LIMIT) begin step(); n++; end
      if (period_start !== 1'b1) begin
         total++; bad++;
         $display("FAIL wait_period_start timeout after %0d clks", n);
      end
   endtask

   // Measures pulse-to-pulse; optionally strobes duty_load at sample load_at.
   task automatic window(input int load_at, input logic [CH-1:0] mask);
      win_len = 0;
      for (int k = 0; k < CH; k++) win_hi[k] = 0;
      wait_pulse();
      if (period_start !== 1'b1) return;
      do begin
         win_len++;
         for (int k = 0; k < CH; k++) if (pwm_out[k] === 1'b1) win_hi[k]++;
         duty_load = (win_len == load_at) ? mask : '0;
         step();
      end while (period_start !== 1'b1 && win_len < LIMIT);
      duty_load = '0;
   endtask

   // ---------------- stimulus ---------------------------------------------
   initial begin : stim
      int hi [CH];
      reset = 1'b1; enable = 1'b0; final_value = '0; duty_bus = '0; duty_load = '0;
      repeat (3) step();
      chk("reset_pwm", 64'(pwm_out), 64'd0);
      chk("reset_ps", 64'(period_start), 64'd0);

      // 1: fv=0, all channels loaded on the first enabled clock
      reset = 1'b0; enable = 1'b1;
      set_slot(0, 64); set_slot(1, 128); set_slot(2, 0); set_slot(3, 256);
      duty_load = '1; step(); duty_load = '0;
      window(0, '0);
      window(0, '0);
      chk("t1_len", 64'(win_len), 64'(per_clk(0)));
      chk("t1_ch0", 64'(win_hi[0]), 64'(exp_hi(64, 0)));
      chk("t1_ch3", 64'(win_hi[3]), 64'(per_clk(0)));

      // 2: fv=3 stretches the period four-fold
      final_value = 8'd3;
      window(0, '0);
      window(0, '0);
      chk("t2_len", 64'(win_len), 64'(per_clk(3)));
      chk("t2_ch1", 64'(win_hi[1]), 64'(exp_hi(128, 3)));

      // 3: 0 stays low, over-range 511 clamps to constant high
      set_slot(2, 0); set_slot(3, 511);
      window(10, 4'b1100);
      for (int w = 0; w < 3; w++) begin
         window(0, '0);
         chk("t3_ch2_low", 64'(win_hi[2]), 64'd0);
         chk("t3_ch3_high", 64'(win_hi[3]), 64'(win_len));
      end

      // 4: mid-period load deferred, boundary-clock load bypasses
      final_value = 8'd0;
      window(0, '0);
      set_slot(0, 192);
      window(100, 4'b0001);
      chk("t4_mid_keep", 64'(win_hi[0]), 64'(exp_hi(64, 0)));
      set_slot(0, 128);
      window(per_clk(0), 4'b0001);
      chk("t4_next_192", 64'(win_hi[0]), 64'(exp_hi(192, 0)));
      window(0, '0);
      chk("t4_bypass_128", 64'(win_hi[0]), 64'(exp_hi(128, 0)));

      // 5: reset mid-period, disabled loading, restart from count 0
      wait_pulse();
      repeat (30) step();
      chk("t5_pre_reset_ch3", 64'(pwm_out[3]), 64'd1);
      reset = 1'b1; step();
      chk("t5_rst_pwm", 64'(pwm_out), 64'd0);
      chk("t5_rst_ps", 64'(period_start), 64'd0);
      reset = 1'b0; enable = 1'b0;
      set_slot(0, 32); set_slot(1, 511); set_slot(2, 16); set_slot(3, 0);
      duty_load = '1; step(); duty_load = '0;
      repeat (9) step();
      chk("t5_disabled_pwm", 64'(pwm_out), 64'd0);
      enable = 1'b1;
      for (int k = 0; k < CH; k++) hi[k] = 0;
      for (int j = 0; j < per_clk(0); j++) begin
         step();
         for (int k = 0; k < CH; k++) if (pwm_out[k] === 1'b1) hi[k]++;
      end
      chk("t5_restart_ch0", 64'(hi[0]), 64'(exp_hi(32, 0)));
      chk("t5_restart_ch1", 64'(hi[1]), 64'(per_clk(0)));
      chk("t5_restart_ch2", 64'(hi[2]), 64'(exp_hi(16, 0)));
      chk("t5_restart_ch3", 64'(hi[3]), 64'd0);

      // 6: literal pins of the model's own period/high-time arithmetic
      window(0, '0);
      chk("t6_len_literal", 64'(win_len), CENTER ? 64'd510 : 64'd256);
      chk("t6_ch0_literal", 64'(win_hi[0]), CENTER ? 64'd63 : 64'd32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
